// File: rtl/ram_request_arbiter_if.sv
// Bundle of cache-side request/wait signals and the single-port RAM bus
// shared between ram_request_arbiter (master) and its environment (slave).
interface ram_request_arbiter_if #(
    parameter int CPUS = 2
);
    logic [CPUS-1:0]    ireq;
    logic [32*CPUS-1:0] iaddr;
    logic [CPUS-1:0]    iwait;
    logic [31:0]        iload;
    logic [CPUS-1:0]    dreq;
    logic [CPUS-1:0]    dwe;
    logic [32*CPUS-1:0] daddr;
    logic [32*CPUS-1:0] dstore;
    logic [CPUS-1:0]    dwait;
    logic [31:0]        dload;
    logic [1:0]         ramstate;
    logic [31:0]        ramload;
    logic               ramREN;
    logic               ramWEN;
    logic [31:0]        ramaddr;
    logic [31:0]        ramstore;

    modport master (
        input  ireq, iaddr, dreq, dwe, daddr, dstore, ramstate, ramload,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport slave (
        output ireq, iaddr, dreq, dwe, daddr, dstore, ramstate, ramload,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/ram_request_arbiter.sv
// Single-port RAM scheduler: data bursts beat instruction fetches, round-robin
// within each class, with a starvation guard that forces a fetch through.
module ram_request_arbiter #(
    parameter int CPUS         = 2,
    parameter int WORDS        = 2,
    parameter int STARVE_LIMIT = 4,
    localparam int OW          = (CPUS > 1) ? $clog2(CPUS) : 1
) (
    input  logic                  CLK,
    input  logic                  nRST,
    ram_request_arbiter_if.master bus,
    output logic [OW-1:0]         owner,
    output logic                  busy,
    output logic                  err
);
    localparam int BW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    localparam logic [1:0]    RAM_ACCESS = 2'd2;
    localparam logic [1:0]    RAM_ERROR  = 2'd3;
    localparam logic [OW-1:0] LAST_ID    = OW'(CPUS - 1);
    localparam logic [BW-1:0] LAST_BEAT  = BW'(WORDS - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [31:0]   BLK_MASK   = 32'(WORDS * 4 - 1);

    typedef enum logic [1:0] {IDLE, IXFER, DXFER} state_t;

    state_t        state, state_n;
    logic [OW-1:0] owner_n, dptr, dptr_n, iptr, iptr_n;
    logic [BW-1:0] beat, beat_n;
    logic [SW-1:0] starve, starve_n;
    logic [31:0]   cur_iaddr, cur_daddr, cur_dstore;
    logic          any_i, any_d;

    function automatic logic [OW-1:0] next_id(input logic [OW-1:0] id);
        return (id == LAST_ID) ? '0 : id + 1'b1;
    endfunction

    // First set request at or after ptr, searching cyclically.
    function automatic logic [OW-1:0] pick(input logic [CPUS-1:0] req,
                                           input logic [OW-1:0]   ptr);
        logic [OW-1:0] idx;
        logic [OW-1:0] win;
        logic          found;
        idx   = ptr;
        win   = ptr;
        found = 1'b0;
        for (int k = 0; k < CPUS; k++) begin
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
            idx = next_id(idx);
        end
        return win;
    endfunction

    assign any_i      = |bus.ireq;
    assign any_d      = |bus.dreq;
    assign cur_iaddr  = bus.iaddr[int'(owner)*32 +: 32];
    assign cur_daddr  = bus.daddr[int'(owner)*32 +: 32];
    assign cur_dstore = bus.dstore[int'(owner)*32 +: 32];
    assign busy       = (state != IDLE);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            owner  <= '0;
            dptr   <= '0;
            iptr   <= '0;
            beat   <= '0;
            starve <= '0;
        end else begin
            state  <= state_n;
            owner  <= owner_n;
            dptr   <= dptr_n;
            iptr   <= iptr_n;
            beat   <= beat_n;
            starve <= starve_n;
        end
    end

    always_comb begin
        state_n      = state;
        owner_n      = owner;
        dptr_n       = dptr;
        iptr_n       = iptr;
        beat_n       = beat;
        starve_n     = starve;
        bus.iwait    = '1;
        bus.dwait    = '1;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iload    = '0;
        bus.dload    = '0;
        err          = 1'b0;

        case (state)
            IDLE: begin
                if (any_d && ((starve < STARVE_MAX) || !any_i)) begin
                    owner_n = pick(bus.dreq, dptr);
                    beat_n  = '0;
                    state_n = DXFER;
                end else if (any_i) begin
                    owner_n = pick(bus.ireq, iptr);
                    state_n = IXFER;
                end
            end

            IXFER: begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = cur_iaddr;
                bus.iload   = bus.ramload;
                if (bus.ramstate == RAM_ERROR) begin
                    err     = 1'b1;
                    state_n = IDLE;
                end else if (bus.ramstate == RAM_ACCESS) begin
                    bus.iwait[owner] = 1'b0;
                    iptr_n           = next_id(owner);
                    starve_n         = '0;
                    state_n          = IDLE;
                end else if (!bus.ireq[owner]) begin
                    state_n = IDLE;
                end
            end

            DXFER: begin
                bus.ramaddr = (cur_daddr & ~BLK_MASK) | 32'({beat, 2'b00});
                if (bus.dwe[owner]) begin
                    bus.ramWEN   = 1'b1;
                    bus.ramstore = cur_dstore;
                end else begin
                    bus.ramREN = 1'b1;
                    bus.dload  = bus.ramload;
                end
                if (bus.ramstate == RAM_ERROR) begin
                    err     = 1'b1;
                    beat_n  = '0;
                    state_n = IDLE;
                end else if (bus.ramstate == RAM_ACCESS) begin
                    bus.dwait[owner] = 1'b0;
                    if (beat == LAST_BEAT) begin
                        beat_n  = '0;
                        dptr_n  = next_id(owner);
                        state_n = IDLE;
                        // Only back-to-back data grants with a fetch waiting count.
                        if (!any_i)
                            starve_n = '0;
                        else if (starve >= STARVE_MAX)
                            starve_n = STARVE_MAX;
                        else
                            starve_n = starve + 1'b1;
                    end else begin
                        beat_n = beat + 1'b1;
                    end
                end else if (!bus.dreq[owner]) begin
                    beat_n  = '0;
                    state_n = IDLE;
                end
            end

            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ram_request_arbiter.sv
// Directed bench for ram_request_arbiter: scripted requesters and RAM responder,
// a transaction-level scheduler model compared every cycle, plus literal pins.
module tb_ram_request_arbiter;
    localparam int CPUS         = 2;
    localparam int WORDS        = 2;
    localparam int STARVE_LIMIT = 4;
    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

    logic                      CLK  = 1'b0;
    logic                      nRST = 1'b0;
    logic [$clog2(CPUS)-1:0]   owner;
    logic                      busy;
    logic                      err;

    ram_request_arbiter_if #(.CPUS(CPUS)) bus ();

    ram_request_arbiter #(
        .CPUS(CPUS), .WORDS(WORDS), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .CLK(CLK), .nRST(nRST), .bus(bus), .owner(owner), .busy(busy), .err(err)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Requester bookkeeping: negedge monitor owns *count/*mark, stimulus owns the rest.
    int dbursts[CPUS], dburstno[CPUS], dbase[CPUS], dcount[CPUS], dmark[CPUS];
    int ifetches[CPUS], ifetchno[CPUS], ibase[CPUS], icount[CPUS];
    int ram_lat    = 1;
    int wait_cnt   = 0;
    int err_budget = -1;
    int cyc        = 0;
    int t_start    = 0;

    typedef struct {
        int          kind;
        int          core;
        logic [31:0] addr;
    } ev_t;
    ev_t evq[$];

    int m_kind, m_core, m_beat, m_dptr, m_iptr, m_starve, m_owner;
    logic [CPUS-1:0] e_iwait, e_dwait;
    logic            e_ren, e_wen, e_err;
    logic [31:0]     e_addr, e_store, e_iload, e_dload;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] store_word(input int core, input int burst, input int beat);
        return 32'hC000_0000 | 32'(core << 12) | 32'(burst << 4) | 32'(beat);
    endfunction

    function automatic int first_set(input logic [CPUS-1:0] r, input int p);
        for (int k = 0; k < CPUS; k++)
            if (r[(p + k) % CPUS]) return (p + k) % CPUS;
        return p;
    endfunction

    function automatic int ev_tag(input int k);
        if (t_start + k < evq.size()) return evq[t_start + k].kind * 16 + evq[t_start + k].core;
        return -1;
    endfunction

    function automatic logic [31:0] ev_addr(input int k);
        if (t_start + k < evq.size()) return evq[t_start + k].addr;
        return 32'hFFFF_FFFF;
    endfunction

    function automatic bit pending();
        for (int i = 0; i < CPUS; i++)
            if (dbursts[i] > 0 || ifetches[i] > 0) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: requesters retire completed work, RAM answers after ram_lat BUSY cycles.
    task automatic applyStimulus();
        @(posedge CLK);
        #1;
        cyc++;
        bus.ramload = 32'hD000_0000 + 32'(cyc);
        for (int i = 0; i < CPUS; i++) begin
            automatic int done_beats = dcount[i] - ((dbase[i] > dmark[i]) ? dbase[i] : dmark[i]);
            if (dbursts[i] > 0 && done_beats >= WORDS) begin
                dbase[i] = dcount[i];
                dbursts[i]--;
                dburstno[i]++;
                done_beats = 0;
                if (dbursts[i] == 0) bus.dreq[i] = 1'b0;
            end
            bus.dstore[32*i +: 32] = store_word(i, dburstno[i], done_beats);
            if (ifetches[i] > 0 && icount[i] > ibase[i]) begin
                ibase[i] = icount[i];
                ifetches[i]--;
                ifetchno[i]++;
                bus.iaddr[32*i +: 32] = 32'h8000_0000 + 32'(i * 256 + ifetchno[i] * 4);
                if (ifetches[i] == 0) bus.ireq[i] = 1'b0;
            end
        end
        if (bus.ramREN || bus.ramWEN) begin
            if (wait_cnt < ram_lat) begin
                bus.ramstate = BUSY;
                wait_cnt++;
            end else begin
                wait_cnt = 0;
                if (err_budget == 0) begin
                    bus.ramstate = ERROR;
                    err_budget   = -1;
                end else begin
                    bus.ramstate = ACCESS;
                    if (err_budget > 0) err_budget--;
                end
            end
        end else begin
            bus.ramstate = FREE;
            wait_cnt     = 0;
        end
    endtask

    task automatic runUntilDone(input int budget, input string name);
        int n = 0;
        while (pending() && n < budget) begin
            applyStimulus();
            n++;
        end
        checks++;
        if (pending()) begin
            errors++;
            $display("[TB] FAIL %s: requests still pending after %0d cycles, required none", name, budget);
        end
        repeat (3) applyStimulus();
    endtask

    // Scheduler model: compare the cycle's outputs, log completions, then advance.
    always @(negedge CLK) begin
        if (!nRST) begin
            m_kind = 0; m_core = 0; m_beat = 0; m_dptr = 0;
            m_iptr = 0; m_starve = 0; m_owner = 0;
        end
        e_iwait = '1; e_dwait = '1; e_ren = 1'b0; e_wen = 1'b0; e_err = 1'b0;
        e_addr = '0; e_store = '0; e_iload = '0; e_dload = '0;
        if (m_kind == 1) begin
            e_ren   = 1'b1;
            e_addr  = bus.iaddr[32*m_core +: 32];
            e_iload = bus.ramload;
            if (bus.ramstate == ACCESS) e_iwait[m_core] = 1'b0;
        end else if (m_kind == 2) begin
            e_addr = (bus.daddr[32*m_core +: 32] / (WORDS * 4)) * (WORDS * 4) + 32'(4 * m_beat);
            if (bus.dwe[m_core]) begin
                e_wen   = 1'b1;
                e_store = bus.dstore[32*m_core +: 32];
            end else begin
                e_ren   = 1'b1;
                e_dload = bus.ramload;
            end
            if (bus.ramstate == ACCESS) e_dwait[m_core] = 1'b0;
        end
        e_err = (m_kind != 0) && (bus.ramstate == ERROR);

        checkOutput("iwait", 32'(bus.iwait), 32'(e_iwait));
        checkOutput("dwait", 32'(bus.dwait), 32'(e_dwait));
        checkOutput("ramREN", 32'(bus.ramREN), 32'(e_ren));
        checkOutput("ramWEN", 32'(bus.ramWEN), 32'(e_wen));
        checkOutput("ramaddr", bus.ramaddr, e_addr);
        checkOutput("ramstore", bus.ramstore, e_store);
        checkOutput("iload", bus.iload, e_iload);
        checkOutput("dload", bus.dload, e_dload);
        checkOutput("busy", 32'(busy), 32'(m_kind != 0));
        checkOutput("err", 32'(err), 32'(e_err));
        checkOutput("owner", 32'(owner), 32'(m_owner));

        for (int i = 0; i < CPUS; i++) begin
            if (!bus.dwait[i]) begin
                dcount[i]++;
                evq.push_back('{kind: 1, core: i, addr: bus.ramaddr});
            end
            if (!bus.iwait[i]) begin
                icount[i]++;
                evq.push_back('{kind: 0, core: i, addr: bus.ramaddr});
            end
            if (!nRST) dmark[i] = dcount[i];
        end
        if (err) begin
            dmark[owner] = dcount[owner];
            evq.push_back('{kind: 2, core: int'(owner), addr: bus.ramaddr});
        end

        if (nRST) begin
            case (m_kind)
                0: begin
                    if ((|bus.dreq) && (m_starve < STARVE_LIMIT || !(|bus.ireq))) begin
                        m_core = first_set(bus.dreq, m_dptr);
                        m_kind = 2;
                        m_beat = 0;
                        m_owner = m_core;
                    end else if (|bus.ireq) begin
                        m_core = first_set(bus.ireq, m_iptr);
                        m_kind = 1;
                        m_owner = m_core;
                    end
                end
                1: begin
                    if (bus.ramstate == ERROR) m_kind = 0;
                    else if (bus.ramstate == ACCESS) begin
                        m_iptr   = (m_core + 1) % CPUS;
                        m_starve = 0;
                        m_kind   = 0;
                    end else if (!bus.ireq[m_core]) m_kind = 0;
                end
                default: begin
                    if (bus.ramstate == ERROR) begin
                        m_kind = 0;
                        m_beat = 0;
                    end else if (bus.ramstate == ACCESS) begin
                        if (m_beat == WORDS - 1) begin
                            m_beat   = 0;
                            m_dptr   = (m_core + 1) % CPUS;
                            m_kind   = 0;
                            m_starve = (|bus.ireq) ? ((m_starve + 1 > STARVE_LIMIT) ? STARVE_LIMIT : m_starve + 1) : 0;
                        end else m_beat++;
                    end else if (!bus.dreq[m_core]) begin
                        m_kind = 0;
                        m_beat = 0;
                    end
                end
            endcase
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.ireq = '0; bus.dreq = '0; bus.dwe = '0;
        bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0;
        bus.ramstate = FREE; bus.ramload = '0;
        for (int i = 0; i < CPUS; i++) begin
            dbursts[i] = 0; dburstno[i] = 0; dbase[i] = 0; dcount[i] = 0; dmark[i] = 0;
            ifetches[i] = 0; ifetchno[i] = 0; ibase[i] = 0; icount[i] = 0;
        end

        @(negedge CLK);
        checkOutput("reset_iwait", 32'(bus.iwait), 32'h3);
        checkOutput("reset_dwait", 32'(bus.dwait), 32'h3);
        checkOutput("reset_enables", 32'({bus.ramREN, bus.ramWEN}), 32'h0);
        checkOutput("reset_busy_owner", 32'({busy, owner}), 32'h0);
        applyStimulus();
        nRST = 1'b1;
        repeat (2) applyStimulus();

        $display("[TB] core0 read burst at 0x104 with two BUSY cycles per beat");
        t_start = evq.size();
        ram_lat = 2;
        bus.daddr[31:0] = 32'h0000_0104;
        bus.dwe[0] = 1'b0;
        dbursts[0] = 1;
        bus.dreq[0] = 1'b1;
        runUntilDone(100, "t1_done");
        checkOutput("t1_events", 32'(evq.size() - t_start), 32'd2);
        checkOutput("t1_addr_beat0", ev_addr(0), 32'h0000_0100);
        checkOutput("t1_addr_beat1", ev_addr(1), 32'h0000_0104);

        nRST = 1'b0;
        applyStimulus();
        nRST = 1'b1;
        applyStimulus();

        $display("[TB] core0 and core1 write bursts together from dptr=0");
        t_start = evq.size();
        ram_lat = 1;
        bus.daddr[31:0]  = 32'h0000_0200;
        bus.daddr[63:32] = 32'h0000_0300;
        bus.dwe = 2'b11;
        dbursts[0] = 1; dbursts[1] = 1;
        bus.dreq = 2'b11;
        runUntilDone(100, "t2_done");
        checkOutput("t2_order0", 32'(ev_tag(0)), 32'd16);
        checkOutput("t2_order2", 32'(ev_tag(2)), 32'd17);
        checkOutput("t2_core1_base", ev_addr(2), 32'h0000_0300);

        $display("[TB] core0 data stream against core1 fetch, starvation guard");
        t_start = evq.size();
        ram_lat = 0;
        bus.dwe = 2'b00;
        bus.daddr[31:0] = 32'h0000_0700;
        bus.iaddr[63:32] = 32'h8000_0100;
        dbursts[0] = 5; ifetches[1] = 1;
        bus.dreq[0] = 1'b1;
        bus.ireq[1] = 1'b1;
        runUntilDone(200, "t3_done");
        checkOutput("t3_events", 32'(evq.size() - t_start), 32'd11);
        checkOutput("t3_last_data_before", 32'(ev_tag(7)), 32'd16);
        checkOutput("t3_fetch_slot", 32'(ev_tag(8)), 32'd1);
        checkOutput("t3_data_resumes", 32'(ev_tag(9)), 32'd16);

        $display("[TB] both cores fetching repeatedly");
        t_start = evq.size();
        ram_lat = 1;
        ifetches[0] = 3; ifetches[1] = 3;
        bus.ireq = 2'b11;
        runUntilDone(200, "t4_done");
        checkOutput("t4_events", 32'(evq.size() - t_start), 32'd6);
        for (int k = 0; k < 6; k++)
            checkOutput($sformatf("t4_grant%0d", k), 32'(ev_tag(k)), 32'(k % 2));

        $display("[TB] core1 read burst with ERROR on beat 1");
        t_start = evq.size();
        err_budget = 1;
        bus.daddr[63:32] = 32'h0000_040C;
        dbursts[1] = 1;
        bus.dreq[1] = 1'b1;
        runUntilDone(100, "t5_done");
        checkOutput("t5_events", 32'(evq.size() - t_start), 32'd4);
        checkOutput("t5_err_slot", 32'(ev_tag(1)), 32'd33);
        checkOutput("t5_retry_beat0", ev_addr(2), 32'h0000_0408);
        checkOutput("t5_retry_beat1", ev_addr(3), 32'h0000_040C);

        $display("[TB] reset during a data burst");
        bus.daddr[31:0] = 32'h0000_0500;
        dbursts[0] = 1;
        bus.dreq[0] = 1'b1;
        runUntilDone(100, "t6_prep_done");
        t_start = evq.size();
        ram_lat = 3;
        bus.daddr[63:32] = 32'h0000_0600;
        dbursts[0] = 1; dbursts[1] = 1;
        bus.dreq = 2'b11;
        applyStimulus();
        @(negedge CLK);
        checkOutput("t6_pre_owner", 32'(owner), 32'd1);
        checkOutput("t6_pre_ren", 32'(bus.ramREN), 32'd1);
        applyStimulus();
        nRST = 1'b0;
        #1;
        checkOutput("t6_async_enables", 32'({bus.ramREN, bus.ramWEN}), 32'h0);
        checkOutput("t6_async_waits", 32'({bus.iwait, bus.dwait}), 32'hF);
        applyStimulus();
        nRST = 1'b1;
        runUntilDone(100, "t6_done");
        checkOutput("t6_first_after_reset", 32'(ev_tag(0)), 32'd16);
        checkOutput("t6_second_core", 32'(ev_tag(2)), 32'd17);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ram_request_arbiter.md
Name: ram_request_arbiter

Overview:
- Single-port RAM scheduler for the multicore memory subsystem. It shares one RAM among CPUS cores, each with an instruction-fetch port and a data port.
- Instruction fetch is a single word. Data read and write are block bursts of WORDS words.
- Data has priority over instruction, with round-robin fairness within each class and a starvation guard so instruction fetches are not locked out.
- Sits between the cache controllers and the RAM model, below coherence sequencing.

Parameters:
CPUS, 2, number of cores (requester pairs); ids 0..CPUS-1
WORDS, 2, words per data burst; power of 2, >=2
STARVE_LIMIT, 4, consecutive data grants allowed while any ireq is pending

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous, active-low reset
ireq  in  CPUS  instruction fetch request per core
iaddr  in  32*CPUS  fetch word address per core, slice [32*i+:32]
iwait  out  CPUS  low for one cycle when core i's fetch word completes
iload  out  32  fetch data, valid when iwait[owner]=0
dreq  in  CPUS  data burst request per core
dwe  in  CPUS  1=write burst, 0=read burst
daddr  in  32*CPUS  data address per core; low log2(WORDS)+2 bits ignored
dstore  in  32*CPUS  write data for the current beat
dwait  out  CPUS  low for one cycle per completed beat
dload  out  32  read data, valid when dwait[owner]=0
ramstate  in  2  cpu_types_pkg ramstate_t: FREE, BUSY, ACCESS, ERROR
ramload  in  32  RAM read data
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  32  RAM word address
ramstore  out  32  RAM write data
owner  out  $clog2(CPUS)  core currently granted
busy  out  1  high in IXFER or DXFER
err  out  1  one-cycle pulse on ramstate==ERROR during a transfer

Behaviour:
- Reset (async): state=IDLE, dptr=iptr=0, beat=0, starve=0, owner=0. Outputs: iwait='1, dwait='1, ramREN=ramWEN=0, ramaddr=ramstore=0, iload=dload=0, busy=0, err=0. Reset mid-transfer drops RAM enables immediately and no wait is released.
- FSM states: IDLE, IXFER, DXFER.
- IDLE arbitration:
  - If any dreq and (starve<STARVE_LIMIT or no ireq): grant the first set dreq at or after dptr, searching cyclically. Go to DXFER, beat=0.
  - Else if any ireq: grant the first set ireq at or after iptr, cyclically. Go to IXFER.
  - The winner is registered into owner. RAM enables assert the cycle after the request is seen, so minimum latency from request to enable is 1 cycle.
- IXFER:
  - ramREN=1, ramaddr=iaddr[owner], iload=ramload.
  - On ACCESS: iwait[owner]=0 for that cycle, iptr=owner+1 (mod CPUS), starve=0, go to IDLE.
- DXFER:
  - ramaddr = block base of daddr[owner] + 4*beat.
  - Write: ramWEN=1, ramstore=dstore[owner]. Read: ramREN=1, dload=ramload.
  - On ACCESS: dwait[owner]=0, beat++.
  - On the last beat (beat==WORDS-1): beat=0, dptr=owner+1 (mod CPUS), go to IDLE. Also starve=starve+1 if any ireq is pending, else 0; saturates at STARVE_LIMIT.
- Aborts:
  - dreq[owner] deasserted mid-burst with no ACCESS that cycle: abort to IDLE, beat=0, pointers unchanged.
  - ireq[owner] deasserted during IXFER: same abort.
- ERROR: in IXFER or DXFER, err=1 for one cycle, no wait released, return to IDLE, pointers unchanged. The requester retries.
- FREE/BUSY: hold state and enables, waits high.
- Never more than one of ramREN/ramWEN is high. Only owner's wait bit can be low.
- IDLE always takes one cycle between grants; back-to-back transfers are not pipelined.
- Requesters hold address, dwe and dstore stable until their wait drops. Changes mid-beat are unspecified.

Test Plan:
- Core0 dreq read, daddr=0x104, WORDS=2, ACCESS after 2 BUSY cycles per beat -> ramaddr 0x100 then 0x104; dwait[0] low twice; dload=ramload; back in IDLE; dptr=1.
- Core0 and core1 dreq write together, dptr=0 -> core0 burst completes, 1 idle cycle, core1 burst; ramWEN high throughout, ramstore tracks dstore[owner].
- Core1 ireq plus core0 dreq pending continuously, STARVE_LIMIT=4 -> 4 data bursts, then core1 fetch granted, then data resumes.
- ireq[0] and ireq[1] together, repeated -> grants alternate 0,1,0,1; iwait released only for owner.
- ramstate=ERROR on beat 1 of core1 read -> err pulses one cycle, dwait[1] stays high for that beat, IDLE, dptr unchanged, core1 re-granted with beat=0.
- nRST asserted during DXFER beat 0 -> ramREN/ramWEN=0 asynchronously, all waits 1; after release, pending request re-arbitrated from dptr=0.
